// File: rtl/idft_frame_ctrl.sv
// Frame sequencer for the streaming idft core. It buffers one input frame, launches it with a
// one-cycle next strobe and a gapless burst, and re-frames the core results. Frames in flight are bounded.
module idft_frame_ctrl #(
  parameter int W            = 16,
  parameter int FRAME_BEATS  = 16,
  parameter int MAX_INFLIGHT = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_data,
  input  logic           in_last,
  output logic           core_next,
  output logic [W-1:0]   core_X0,
  output logic [W-1:0]   core_X1,
  output logic [W-1:0]   core_X2,
  output logic [W-1:0]   core_X3,
  input  logic           core_next_out,
  input  logic [W-1:0]   core_Y0,
  input  logic [W-1:0]   core_Y1,
  input  logic [W-1:0]   core_Y2,
  input  logic [W-1:0]   core_Y3,
  output logic           out_valid,
  output logic [4*W-1:0] out_data,
  output logic           out_first,
  output logic           out_last,
  output logic           busy,
  output logic           err_frame,
  output logic           err_timeout,
  output logic [15:0]    frames_done
);
  localparam int CW = $clog2(FRAME_BEATS + 1);
  localparam int IW = $clog2(FRAME_BEATS);
  localparam int FW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] NBEATS   = CW'(FRAME_BEATS);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BEATS - 1);
  localparam logic [FW-1:0] MAX_IF   = FW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_LAUNCH, S_STREAM} state_t;

  logic [4*W-1:0] mem_q [FRAME_BEATS];

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IW-1:0]  rd_q, rd_d;
  logic [FW-1:0]  inflight_q, inflight_d;
  logic [TW-1:0]  wd_q, wd_d;
  logic           cap_act_q, cap_act_d;
  logic [CW-1:0]  cap_idx_q, cap_idx_d;
  logic           in_ready_q, in_ready_d;
  logic           core_next_q, core_next_d;
  logic [4*W-1:0] core_x_q, core_x_d;
  logic           out_valid_q, out_valid_d;
  logic [4*W-1:0] out_data_q, out_data_d;
  logic           out_first_q, out_first_d;
  logic           out_last_q, out_last_d;
  logic           busy_q, busy_d;
  logic           err_frame_q, err_frame_d;
  logic           err_timeout_q, err_timeout_d;
  logic [15:0]    frames_done_q, frames_done_d;
  logic           wr_en, launch, done, timeout;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_d          = rd_q;
    wd_d          = wd_q;
    cap_act_d     = cap_act_q;
    cap_idx_d     = cap_idx_q;
    core_next_d   = 1'b0;
    core_x_d      = '0;
    out_valid_d   = 1'b0;
    out_data_d    = '0;
    out_first_d   = 1'b0;
    out_last_d    = 1'b0;
    err_frame_d   = err_frame_q;
    err_timeout_d = err_timeout_q;
    wr_en         = 1'b0;
    launch        = 1'b0;
    done          = 1'b0;
    timeout       = 1'b0;

    case (state_q)
      S_FILL: begin
        if (in_valid && in_ready_q) begin
          wr_en = 1'b1;
          if (count_q == LAST_CNT) begin
            count_d = '0;
            if (in_last) state_d = S_WAIT;
            else         err_frame_d = 1'b1;
          end else if (in_last) begin
            // Short frame: drop what was buffered and start over.
            count_d     = '0;
            err_frame_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (inflight_q < MAX_IF) begin
          state_d     = S_LAUNCH;
          core_next_d = 1'b1;
          launch      = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d  = S_STREAM;
        rd_d     = '0;
        core_x_d = mem_q[0];
      end
      default: begin
        if (rd_q == LAST_IDX) begin
          state_d = S_FILL;
          count_d = '0;
        end else begin
          rd_d     = rd_q + IW'(1);
          core_x_d = mem_q[rd_q + IW'(1)];
        end
      end
    endcase

    // Result capture: beat k of the core arrives k cycles after its strobe.
    if (cap_act_q) begin
      out_valid_d = 1'b1;
      out_data_d  = {core_Y0, core_Y1, core_Y2, core_Y3};
      out_first_d = (cap_idx_q == CW'(1));
      if (cap_idx_q == NBEATS) begin
        out_last_d = 1'b1;
        cap_act_d  = 1'b0;
        done       = 1'b1;
      end else begin
        cap_idx_d = cap_idx_q + CW'(1);
      end
      if (core_next_out) err_frame_d = 1'b1;
    end else if (core_next_out) begin
      cap_act_d = 1'b1;
      cap_idx_d = CW'(1);
    end

    if (state_q == S_LAUNCH || core_next_out) begin
      wd_d = '0;
    end else if (inflight_q != '0 && !cap_act_q) begin
      if (wd_q == WD_LAST) begin
        wd_d          = '0;
        err_timeout_d = 1'b1;
        timeout       = 1'b1;
      end else begin
        wd_d = wd_q + TW'(1);
      end
    end

    inflight_d = inflight_q;
    if (timeout)                            inflight_d = '0;
    else if (done && inflight_q != '0)      inflight_d = inflight_q - FW'(1);
    if (launch)                             inflight_d = inflight_d + FW'(1);

    frames_done_d = frames_done_q + {15'd0, done};
    in_ready_d    = (state_d == S_FILL) && (count_d < NBEATS);
    busy_d        = !((state_d == S_FILL) && (count_d == '0) && (inflight_d == '0));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[IW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FILL;
      count_q       <= '0;
      rd_q          <= '0;
      inflight_q    <= '0;
      wd_q          <= '0;
      cap_act_q     <= 1'b0;
      cap_idx_q     <= '0;
      in_ready_q    <= 1'b0;
      core_next_q   <= 1'b0;
      core_x_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_q          <= rd_d;
      inflight_q    <= inflight_d;
      wd_q          <= wd_d;
      cap_act_q     <= cap_act_d;
      cap_idx_q     <= cap_idx_d;
      in_ready_q    <= in_ready_d;
      core_next_q   <= core_next_d;
      core_x_q      <= core_x_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_first_q   <= out_first_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign core_next   = core_next_q;
  assign core_X0     = core_x_q[4*W-1 -: W];
  assign core_X1     = core_x_q[3*W-1 -: W];
  assign core_X2     = core_x_q[2*W-1 -: W];
  assign core_X3     = core_x_q[W-1 -: W];
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;
  assign frames_done = frames_done_q;
endmodule

// File: tb/tb_idft_frame_ctrl.sv
// Directed bench for idft_frame_ctrl: a main instance plus a short-watchdog instance sharing stimulus.
module tb_idft_frame_ctrl;
  logic        clk, rst, in_valid, in_last, cno;
  logic [63:0] in_data;
  logic [15:0] cy0, cy1, cy2, cy3;
  logic        in_ready, core_next, out_valid, out_first, out_last, busy, err_frame, err_timeout;
  logic [15:0] cx0, cx1, cx2, cx3, frames_done;
  logic [63:0] out_data;
  logic        w_in_ready, w_core_next, w_out_valid, w_out_first, w_out_last, w_busy, w_err_frame, w_err_timeout;
  logic [15:0] w_cx0, w_cx1, w_cx2, w_cx3, w_frames_done;
  logic [63:0] w_out_data;
  int npass = 0;
  int ntot  = 0;

  idft_frame_ctrl #(.W(16), .FRAME_BEATS(16), .MAX_INFLIGHT(2), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .core_next(core_next), .core_X0(cx0), .core_X1(cx1), .core_X2(cx2),
    .core_X3(cx3), .core_next_out(cno), .core_Y0(cy0), .core_Y1(cy1), .core_Y2(cy2),
    .core_Y3(cy3), .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout),
    .frames_done(frames_done));

  idft_frame_ctrl #(.W(16), .FRAME_BEATS(16), .MAX_INFLIGHT(2), .TIMEOUT(20)) dut_wd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .in_last(in_last), .core_next(w_core_next), .core_X0(w_cx0), .core_X1(w_cx1), .core_X2(w_cx2),
    .core_X3(w_cx3), .core_next_out(cno), .core_Y0(cy0), .core_Y1(cy1), .core_Y2(cy2),
    .core_Y3(cy3), .out_valid(w_out_valid), .out_data(w_out_data), .out_first(w_out_first),
    .out_last(w_out_last), .busy(w_busy), .err_frame(w_err_frame), .err_timeout(w_err_timeout),
    .frames_done(w_frames_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pat(input int f, input int b);
    logic [15:0] s;
    s = 16'(f * 256 + b * 4);
    return {s, s + 16'd1, s + 16'd2, s + 16'd3};
  endfunction

  // Stand-in core transform: pairwise butterflies.
  function automatic logic [63:0] bfly(input logic [63:0] x);
    logic [15:0] a, b, c, d;
    {a, b, c, d} = x;
    return {16'(a + b), 16'(a - b), 16'(c + d), 16'(c - d)};
  endfunction

  task automatic send_frame(input int f, input int bad);
    for (int b = 0; b < 16; b++) begin
      in_valid = 1'b1;
      in_data  = pat(f, b);
      in_last  = (b == 15) || (b == bad);
      step();
      if (b == bad) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in the cycle before the launch is due.
  task automatic expect_launch(input int f);
    step();
    check("core_next_strobe", core_next, 1'b1);
    for (int b = 0; b < 16; b++) begin
      step();
      check($sformatf("core_x_f%0d_b%0d", f, b), {core_next, cx0, cx1, cx2, cx3}, {1'b0, pat(f, b)});
    end
    step();
    check("stream_end", {cx0, cx1, cx2, cx3, in_ready}, {64'd0, 1'b1});
  endtask

  // Ends in the out_last cycle.
  task automatic play_result(input int f, input int exp_done);
    cno = 1'b1;
    step();
    cno = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      {cy0, cy1, cy2, cy3} = bfly(pat(f, k - 1));
      step();
      check($sformatf("result_f%0d_k%0d", f, k), {out_valid, out_first, out_last, out_data},
            {1'b1, 1'(k == 1), 1'(k == 16), bfly(pat(f, k - 1))});
    end
    {cy0, cy1, cy2, cy3} = 64'd0;
    check("frames_done", frames_done, 16'(exp_done));
  endtask

  initial begin
    int  b, iter;
    logic early, acc;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; cno = 1'b0;
    {cy0, cy1, cy2, cy3} = 64'd0;
    step(); step();
    check("reset_outputs", {in_ready, core_next, out_valid, busy, err_frame, err_timeout, frames_done}, '0);
    rst = 1'b1;
    step();
    check("ready_after_release", {in_ready, busy}, 2'b10);

    // Single gapless frame
    send_frame(1, -1);
    check("wait_state", {core_next, in_ready, busy}, 3'b001);
    expect_launch(1);
    play_result(1, 1);
    step();
    check("out_idle", {out_valid, out_first, out_last}, 3'b000);

    // Throttled input
    early = 1'b0; b = 0; iter = 0;
    while (b < 16 && iter < 2000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = pat(2, b);
      in_last  = (b == 15);
      acc      = in_valid;
      step();
      early |= core_next;
      if (acc) b++;
      iter++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("throttle_fill", b, 16);
    check("no_early_launch", early, 1'b0);
    expect_launch(2);

    // Inflight limit: frame 2 result withheld, frame 3 launches, frame 4 must wait
    send_frame(3, -1);
    expect_launch(3);
    send_frame(4, -1);
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      early |= core_next;
    end
    check("held_in_wait", {early, in_ready, busy}, 3'b001);
    play_result(2, 2);
    check("no_launch_at_out_last", core_next, 1'b0);
    expect_launch(4);
    play_result(3, 3);
    play_result(4, 4);
    check("idle_after_drain", busy, 1'b0);

    // Framing error: in_last on the fifth beat
    send_frame(9, 4);
    check("err_frame_set", {err_frame, in_ready}, 2'b11);
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      early |= core_next;
    end
    check("discard_no_launch", {early, busy}, 2'b00);
    send_frame(5, -1);
    expect_launch(5);
    play_result(5, 5);
    check("err_frame_sticky", {err_frame, err_timeout}, 2'b10);

    // Reset while streaming beat 7
    send_frame(6, -1);
    step();
    check("launch_f6", core_next, 1'b1);
    for (int i = 0; i < 8; i++) step();
    check("stream_beat7", {cx0, cx1, cx2, cx3}, pat(6, 7));
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", {in_ready, core_next, cx0, cx1, cx2, cx3, out_valid, out_first,
          out_last, out_data, busy, err_frame, err_timeout, frames_done}, '0);
    step();
    rst = 1'b1;
    step();
    check("ready_after_mid_reset", {in_ready, busy, err_frame, frames_done}, {1'b1, 1'b0, 1'b0, 16'd0});

    // Clean frame after reset; short-watchdog instance times out at launch+21
    send_frame(7, -1);
    expect_launch(7);
    step(); step(); step();
    check("wd_before_timeout", {w_err_timeout, w_busy}, 2'b01);
    step();
    check("wd_timeout", {w_err_timeout, w_busy, err_timeout, busy}, 4'b1001);
    play_result(7, 1);
    send_frame(8, -1);
    step();
    check("launch_after_timeout", {core_next, w_core_next, w_err_timeout}, 3'b111);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/idft_frame_ctrl.md
# idft_frame_ctrl

Frame sequencer that sits between a valid/ready sample stream and the streaming `idft` core. It buffers one complete frame of input beats (four 16-bit samples per beat), launches it into the core with the mandatory one-cycle `next` strobe followed by a gapless burst, and re-times the core's `next_out`-framed result burst onto a framed output stream. It also bounds the number of frames in flight, checks frame framing and watchdogs the core for lost results.

## Interface
Parameters:
- `W`, 16, sample width; one beat is `4*W` bits.
- `FRAME_BEATS`, 16, beats per frame; must be ≥ 2.
- `MAX_INFLIGHT`, 2, maximum frames launched but not yet fully output; must be ≥ 1.
- `TIMEOUT`, 1023, maximum cycles with frames in flight and no result activity.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: controller accepts a beat; transfer occurs when `in_valid & in_ready`.
- `in_data` in 4W: beat `{X0,X1,X2,X3}`, with X0 in the MSBs.
- `in_last` in 1: marks the final beat of a frame.
- `core_next` out 1: launch strobe to the core.
- `core_X0..core_X3` out W each: core input samples.
- `core_next_out` in 1: core result strobe.
- `core_Y0..core_Y3` in W each: core result samples.
- `out_valid` out 1: result beat valid; there is no backpressure.
- `out_data` out 4W: result beat `{Y0,Y1,Y2,Y3}`.
- `out_first` out 1, `out_last` out 1: first and last beat of a result frame.
- `busy` out 1: high unless the controller is in FILL with count 0 and inflight 0.
- `err_frame` out 1: sticky framing error.
- `err_timeout` out 1: sticky watchdog error.
- `frames_done` out 16: completed output frames, wraps modulo 2^16.

## Operation
- Input buffer: `FRAME_BEATS` × `4W` memory, write pointer `count`.
- Input FSM states:
  - FILL:
    - `in_ready` = (`count` < `FRAME_BEATS`).
    - Each accepted beat is written at `count`, then `count` increments.
    - `in_last` on beat index `FRAME_BEATS-1` → go to WAIT.
    - `in_last` on an earlier beat, or no `in_last` on the final beat → set `err_frame`, clear `count` (frame discarded), stay in FILL.
  - WAIT: `in_ready`=0. If `inflight` < `MAX_INFLIGHT` → LAUNCH.
  - LAUNCH: `core_next`=1 for exactly this cycle. `inflight` increments. Go to STREAM and clear the read index.
  - STREAM: `core_X*` is driven from buffer index 0..`FRAME_BEATS-1` on consecutive cycles. After the last index → FILL with `count`=0.
- `core_X*` = 0 whenever the FSM is not in STREAM.
- Output side:
  - `core_next_out` sampled high starts capture. The core presents beat k during the k-th cycle after the strobe (k = 1..`FRAME_BEATS`).
  - Each captured beat is registered, so `out_valid` lags the core by one cycle.
  - `out_first` accompanies beat 1 and `out_last` accompanies beat `FRAME_BEATS`.
  - On the `out_last` cycle, `inflight` decrements and `frames_done` increments.
- `core_next_out` while a capture is active: set `err_frame`, ignore the strobe, and let the current capture finish.
- Launch and completion in the same cycle: `inflight` is unchanged.
- Watchdog:
  - The counter runs while `inflight` > 0 and no capture is active.
  - It resets on LAUNCH or `core_next_out`.
  - On reaching `TIMEOUT`: set `err_timeout`, force `inflight`=0, and clear the counter.
- Sticky errors clear only on reset.
- Reset (asynchronous, at any point, including mid-STREAM or mid-capture):
  - FSM → FILL; `count`, `inflight`, watchdog and `frames_done` = 0.
  - All outputs 0: `in_ready`, `core_next`, `core_X*`, `out_*`, `busy`, `err_*`.
  - `in_ready` rises on the first clock after reset release.
  - A partial frame is lost. Result beats arriving after reset release without a new `core_next_out` are ignored.

## Timing
- All outputs are registered.
- Last input beat accepted at edge T:
  - WAIT during T→T+1.
  - `core_next` high during cycle T+1 if `inflight` permits; otherwise delayed until it does.
  - First `core_X` beat in cycle T+2.
  - Last `core_X` beat in cycle T+1+`FRAME_BEATS`.
  - `in_ready` high again in the following cycle.
- Minimum frame period: `FRAME_BEATS` (fill) + 1 (WAIT) + 1 (LAUNCH) + `FRAME_BEATS` (STREAM) cycles.
- `core_next_out` high in cycle E:
  - `out_valid` high in cycles E+2 .. E+1+`FRAME_BEATS`, contiguous.
  - `out_last` in cycle E+1+`FRAME_BEATS`.
- `busy` and `frames_done` update one cycle after the causing event.

## Test plan
- Reset and single frame (`FRAME_BEATS`=16), gapless input:
  - `core_next` is high exactly one cycle, at T+1.
  - 16 `core_X` beats match the input in order.
  - Drive `core_next_out` from a reference `idft` model; `out_data` equals the model results, with `out_first`/`out_last` on beats 1/16 and `frames_done`=1.
- Throttled input (`in_valid` 50% random): frames are launched only when full, and `core_X` stays gapless.
- `MAX_INFLIGHT`=2 and the core result withheld: the third full frame waits in WAIT. Releasing one result → launch occurs exactly 1 cycle after that frame's `out_last`.
- Framing errors:
  - `in_last` on beat 5 → `err_frame`=1, no launch.
  - The next correct frame launches and completes normally.
- Watchdog with `TIMEOUT`=20: after a launch with no `core_next_out` → `err_timeout`=1 at launch+21 cycles, `inflight`=0, and a new frame can launch.
- Reset asserted mid-STREAM (beat 7): all outputs go to 0 immediately; after release, `in_ready`=1 and the next frame runs cleanly.
